// File: rtl/interp_tile_seq.sv
// interp_tile_seq: steps the plane-equation interpolator through the covered
// rows of one 32x32 tile for each accepted triangle. A triangle first holds
// the interpolator setup enable for SETUP_CYCLES cycles, then waits one settle
// cycle, then presents one row per downstream handshake.
module interp_tile_seq #(
  parameter int SETUP_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [4:0]  tile_x,
  input  logic [4:0]  tile_y,
  input  logic [4:0]  row_first,
  input  logic [4:0]  row_last,
  input  logic        abort,
  output logic        setup,
  output logic [11:0] x_ps,
  output logic [11:0] y_ps,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [4:0]  row_idx,
  output logic        row_end,
  output logic        tri_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SETTLE,
    ROWS,
    DONE
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

  state_t     state;
  logic [7:0] setup_cnt;
  logic [4:0] tile_x_q;
  logic [4:0] tile_y_q;
  logic [4:0] row_first_q;
  logic [4:0] row_last_q;
  logic [4:0] next_row;

  // Row after the current one; only used when row_end is low, so it never
  // has to wrap past 31.
  assign next_row = row_idx + 5'd1;

  // Single sequencer: state, latched request fields and every registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      setup_cnt   <= 8'd0;
      tile_x_q    <= 5'd0;
      tile_y_q    <= 5'd0;
      row_first_q <= 5'd0;
      row_last_q  <= 5'd0;
      tri_ready   <= 1'b0;
      setup       <= 1'b0;
      x_ps        <= 12'd0;
      y_ps        <= 12'd0;
      row_valid   <= 1'b0;
      row_idx     <= 5'd0;
      row_end     <= 1'b0;
      tri_done    <= 1'b0;
      busy        <= 1'b0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      setup_cnt <= 8'd0;
      tri_ready <= 1'b0;
      setup     <= 1'b0;
      x_ps      <= 12'd0;
      y_ps      <= 12'd0;
      row_valid <= 1'b0;
      row_idx   <= 5'd0;
      row_end   <= 1'b0;
      tri_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tri_valid && tri_ready) begin
            tile_x_q    <= tile_x;
            tile_y_q    <= tile_y;
            row_first_q <= row_first;
            row_last_q  <= row_last;
            x_ps        <= {2'b00, tile_x, 5'b00000};
            tri_ready   <= 1'b0;
            busy        <= 1'b1;
            setup_cnt   <= 8'd0;
            if (row_first > row_last) begin
              state    <= DONE;
              tri_done <= 1'b1;
            end else begin
              state <= SETUP;
              setup <= 1'b1;
            end
          end else begin
            tri_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state <= SETTLE;
            setup <= 1'b0;
          end else begin
            setup_cnt <= setup_cnt + 8'd1;
          end
        end
        SETTLE: begin
          state     <= ROWS;
          row_idx   <= row_first_q;
          y_ps      <= {2'b00, tile_y_q, row_first_q};
          row_valid <= 1'b1;
          row_end   <= (row_first_q == row_last_q);
        end
        ROWS: begin
          if (row_ready) begin
            if (row_end) begin
              state     <= DONE;
              row_valid <= 1'b0;
              row_end   <= 1'b0;
              tri_done  <= 1'b1;
            end else begin
              row_idx <= next_row;
              y_ps    <= {2'b00, tile_y_q, next_row};
              row_end <= (next_row == row_last_q);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          tri_done  <= 1'b0;
          busy      <= 1'b0;
          tri_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interp_tile_seq.sv
// Directed bench for interp_tile_seq with SETUP_CYCLES = 4.
module tb_interp_tile_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        tri_valid;
  logic        tri_ready;
  logic [4:0]  tile_x;
  logic [4:0]  tile_y;
  logic [4:0]  row_first;
  logic [4:0]  row_last;
  logic        abort;
  logic        setup;
  logic [11:0] x_ps;
  logic [11:0] y_ps;
  logic        row_valid;
  logic        row_ready;
  logic [4:0]  row_idx;
  logic        row_end;
  logic        tri_done;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  interp_tile_seq #(.SETUP_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tile_x(tile_x), .tile_y(tile_y),
    .row_first(row_first), .row_last(row_last),
    .abort(abort), .setup(setup),
    .x_ps(x_ps), .y_ps(y_ps),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .row_end(row_end),
    .tri_done(tri_done), .busy(busy)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for tri_ready, then present one request for one edge.
  task automatic applyStimulus(input logic [4:0] tx, input logic [4:0] ty,
                               input logic [4:0] rf, input logic [4:0] rl);
    for (int i = 0; i < 20 && !tri_ready; i++) tick();
    checkOutput("accept_ready", int'(tri_ready), 1);
    tile_x    = tx;
    tile_y    = ty;
    row_first = rf;
    row_last  = rl;
    tri_valid = 1'b1;
    tick();
    tri_valid = 1'b0;
  endtask

  int bp_ready [5] = '{1, 0, 0, 1, 1};
  int bp_row   [5] = '{5, 6, 6, 6, 7};

  initial begin
    reset = 1'b1; tri_valid = 1'b0; abort = 1'b0; row_ready = 1'b0;
    tile_x = 5'd0; tile_y = 5'd0; row_first = 5'd0; row_last = 5'd0;

    // Reset state.
    tick(); tick();
    checkOutput("rst_tri_ready", int'(tri_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_setup", int'(setup), 0);
    checkOutput("rst_row_valid", int'(row_valid), 0);
    checkOutput("rst_x_ps", int'(x_ps), 0);
    checkOutput("rst_tri_done", int'(tri_done), 0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_tri_ready", int'(tri_ready), 1);

    // Basic triangle: tile (3,2), rows 0..31, no backpressure.
    row_ready = 1'b1;
    applyStimulus(5'd3, 5'd2, 5'd0, 5'd31);
    checkOutput("basic_busy", int'(busy), 1);
    checkOutput("basic_tri_ready", int'(tri_ready), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("basic_setup_hi", int'(setup), 1);
      tick();
    end
    checkOutput("basic_settle_setup", int'(setup), 0);
    checkOutput("basic_settle_valid", int'(row_valid), 0);
    tick();
    for (int r = 0; r < 32; r++) begin
      checkOutput("basic_row_valid", int'(row_valid), 1);
      checkOutput("basic_x_ps", int'(x_ps), 96);
      checkOutput("basic_y_ps", int'(y_ps), 64 + r);
      checkOutput("basic_row_end", int'(row_end), (r == 31) ? 1 : 0);
      checkOutput("basic_no_done", int'(tri_done), 0);
      tick();
    end
    checkOutput("basic_done", int'(tri_done), 1);
    checkOutput("basic_valid_off", int'(row_valid), 0);
    tick();
    checkOutput("basic_done_once", int'(tri_done), 0);
    checkOutput("basic_idle_ready", int'(tri_ready), 1);
    checkOutput("basic_idle_busy", int'(busy), 0);

    // Backpressure: tile_y = 1, rows 5..7, ready pattern 1,0,0,1,1.
    applyStimulus(5'd0, 5'd1, 5'd5, 5'd7);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", int'(row_valid), 1);
      checkOutput("bp_y_ps", int'(y_ps), 32 + bp_row[i]);
      checkOutput("bp_row_end", int'(row_end), (i == 4) ? 1 : 0);
      row_ready = (bp_ready[i] != 0);
      tick();
    end
    checkOutput("bp_done", int'(tri_done), 1);
    tick();
    row_ready = 1'b1;

    // Empty span: 9 > 4, no setup, done at T+1, ready at T+2.
    applyStimulus(5'd1, 5'd1, 5'd9, 5'd4);
    checkOutput("empty_done", int'(tri_done), 1);
    checkOutput("empty_setup", int'(setup), 0);
    checkOutput("empty_busy", int'(busy), 1);
    tick();
    checkOutput("empty_ready", int'(tri_ready), 1);
    checkOutput("empty_done_off", int'(tri_done), 0);
    checkOutput("empty_setup2", int'(setup), 0);

    // Single row at the tile edge: tile_y = 31, row 31.
    applyStimulus(5'd0, 5'd31, 5'd31, 5'd31);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("edge_valid", int'(row_valid), 1);
    checkOutput("edge_y_ps", int'(y_ps), 1023);
    checkOutput("edge_row_end", int'(row_end), 1);
    checkOutput("edge_row_idx", int'(row_idx), 31);
    tick();
    checkOutput("edge_done", int'(tri_done), 1);
    checkOutput("edge_valid_off", int'(row_valid), 0);
    checkOutput("edge_no_wrap", int'(row_idx), 31);
    tick();

    // Abort during setup cycle 2.
    applyStimulus(5'd2, 5'd2, 5'd0, 5'd3);
    tick();
    checkOutput("abs_setup_c2", int'(setup), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abs_busy", int'(busy), 0);
    checkOutput("abs_setup", int'(setup), 0);
    checkOutput("abs_no_done", int'(tri_done), 0);
    checkOutput("abs_ready_low", int'(tri_ready), 0);
    tick();
    checkOutput("abs_ready", int'(tri_ready), 1);

    // New request after abort, then abort in ROWS together with row_ready.
    applyStimulus(5'd1, 5'd1, 5'd2, 5'd3);
    checkOutput("ab2_setup", int'(setup), 1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("ab2_settle", int'(setup), 0);
    tick();
    checkOutput("ab2_valid", int'(row_valid), 1);
    checkOutput("ab2_y_ps", int'(y_ps), 34);
    checkOutput("ab2_x_ps", int'(x_ps), 32);
    abort = 1'b1;
    row_ready = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abr_valid", int'(row_valid), 0);
    checkOutput("abr_no_done", int'(tri_done), 0);
    checkOutput("abr_busy", int'(busy), 0);
    checkOutput("abr_y_ps", int'(y_ps), 0);
    tick();
    checkOutput("abr_no_done2", int'(tri_done), 0);
    checkOutput("abr_ready", int'(tri_ready), 1);

    // Reset in the middle of ROWS.
    applyStimulus(5'd2, 5'd3, 5'd0, 5'd3);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rr_y_first", int'(y_ps), 96);
    tick();
    checkOutput("rr_y_second", int'(y_ps), 97);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rr_valid", int'(row_valid), 0);
    checkOutput("rr_y_ps", int'(y_ps), 0);
    checkOutput("rr_x_ps", int'(x_ps), 0);
    checkOutput("rr_row_idx", int'(row_idx), 0);
    checkOutput("rr_busy", int'(busy), 0);
    checkOutput("rr_tri_ready", int'(tri_ready), 0);
    tick();
    checkOutput("rr_ready_after", int'(tri_ready), 1);

    // Back-to-back triangle after reset: tile (4,5), rows 1..2.
    applyStimulus(5'd4, 5'd5, 5'd1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b_setup", int'(setup), 1);
      tick();
    end
    tick();
    checkOutput("b2b_x_ps", int'(x_ps), 128);
    checkOutput("b2b_y_ps0", int'(y_ps), 161);
    checkOutput("b2b_end0", int'(row_end), 0);
    tick();
    checkOutput("b2b_y_ps1", int'(y_ps), 162);
    checkOutput("b2b_end1", int'(row_end), 1);
    tick();
    checkOutput("b2b_done", int'(tri_done), 1);
    tick();
    checkOutput("b2b_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
